// File: rtl/gpr_wb_arb.sv
// Write-back arbiter for the GPR write port: the pipeline always wins, and
// mult/div results wait in a small in-order FIFO until the port is free.
module gpr_wb_arb #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_a3,
    input  logic [31:0]      pipe_wd,
    input  logic [31:0]      pipe_pc,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [4:0]       md_a3,
    input  logic [31:0]      md_wd,
    input  logic [31:0]      md_pc,
    output logic             gpr_we,
    output logic [4:0]       gpr_a3,
    output logic [31:0]      gpr_wd,
    output logic [31:0]      gpr_pc,
    output logic [31:0]      pend_mask,
    output logic [PTR_W:0]   fifo_cnt,
    output logic             waw_err
);

    logic [4:0]       q_a3 [DEPTH];
    logic [31:0]      q_wd [DEPTH];
    logic [31:0]      q_pc [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             pipe_issue;
    logic             push;
    logic             pop;
    logic [31:0]      fifo_mask;
    logic [31:0]      out_mask;

    assign fifo_cnt   = cnt;
    assign md_ready   = !reset && (cnt != (PTR_W+1)'(DEPTH));
    // A pipeline write to $0 is treated as idle so the FIFO can drain.
    assign pipe_issue = pipe_we && (pipe_a3 != 5'd0);
    assign push       = md_valid && md_ready && (md_a3 != 5'd0);
    assign pop        = !pipe_issue && (cnt != '0);

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        fifo_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PTR_W'(i) - rd_ptr} < cnt) begin
                fifo_mask[q_a3[i]] = 1'b1;
            end
        end
    end

    assign out_mask  = gpr_we ? (32'd1 << gpr_a3) : 32'd0;
    assign pend_mask = (fifo_mask | out_mask) & ~32'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            q_a3[wr_ptr] <= md_a3;
            q_wd[wr_ptr] <= md_wd;
            q_pc[wr_ptr] <= md_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            gpr_we  <= 1'b0;
            gpr_a3  <= '0;
            gpr_wd  <= '0;
            gpr_pc  <= '0;
            waw_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            if (pipe_issue) begin
                gpr_we <= 1'b1;
                gpr_a3 <= pipe_a3;
                gpr_wd <= pipe_wd;
                gpr_pc <= pipe_pc;
                // Only a queued entry counts; the output stage is already ahead.
                if (fifo_mask[pipe_a3]) waw_err <= 1'b1;
            end else if (pop) begin
                gpr_we <= 1'b1;
                gpr_a3 <= q_a3[rd_ptr];
                gpr_wd <= q_wd[rd_ptr];
                gpr_pc <= q_pc[rd_ptr];
            end else begin
                gpr_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Self-checking bench for gpr_wb_arb: directed vector table, hand sequences,
// and random traffic checked against a queue-based reference model.
module tb_gpr_wb_arb;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             pipe_we;
    logic [4:0]       pipe_a3;
    logic [31:0]      pipe_wd;
    logic [31:0]      pipe_pc;
    logic             md_valid;
    logic             md_ready;
    logic [4:0]       md_a3;
    logic [31:0]      md_wd;
    logic [31:0]      md_pc;
    logic             gpr_we;
    logic [4:0]       gpr_a3;
    logic [31:0]      gpr_wd;
    logic [31:0]      gpr_pc;
    logic [31:0]      pend_mask;
    logic [PTR_W:0]   fifo_cnt;
    logic             waw_err;

    gpr_wb_arb #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
        .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd), .gpr_pc(gpr_pc),
        .pend_mask(pend_mask), .fifo_cnt(fifo_cnt), .waw_err(waw_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  pa3;
        logic [31:0] pwd;
        logic [31:0] ppc;
        logic        mv;
        logic [4:0]  ma3;
        logic [31:0] mwd;
        logic [31:0] mpc;
    } stim_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [31:0] pend;
        logic [31:0] cnt;
        logic        ready;
        logic        waw;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a plain queue plus the output-stage registers.
    ent_t        mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_pc = '0;
    logic        m_waw = 1'b0;
    logic [4:0]  obs[$];

    function automatic stim_t mk(input logic rst, input logic pwe, input logic [4:0] pa3,
                                 input logic [31:0] pwd, input logic mv, input logic [4:0] ma3,
                                 input logic [31:0] mwd);
        stim_t s;
        s.rst = rst; s.pwe = pwe; s.pa3 = pa3; s.pwd = pwd; s.ppc = pwd + 32'h1000;
        s.mv = mv; s.ma3 = ma3; s.mwd = mwd; s.mpc = mwd + 32'h2000;
        return s;
    endfunction

    function automatic exp_t mke(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                 input logic [31:0] pc, input logic [31:0] pend,
                                 input int cnt, input logic ready, input logic waw);
        exp_t e;
        e.we = we; e.a3 = a3; e.wd = wd; e.pc = pc; e.pend = pend;
        e.cnt = 32'(cnt); e.ready = ready; e.waw = waw;
        return e;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.we = m_we; e.a3 = m_a3; e.wd = m_wd; e.pc = m_pc; e.waw = m_waw;
        e.pend = '0;
        foreach (mq[i]) e.pend[mq[i].a3] = 1'b1;
        if (m_we) e.pend[m_a3] = 1'b1;
        e.pend[0] = 1'b0;
        e.cnt = 32'(mq.size());
        e.ready = !reset && (mq.size() != DEPTH);
        return e;
    endfunction

    task automatic checkField(input string tag, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s.%s at %0t: got %h, expected %h", tag, name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        vectors++;
        checkField(tag, "gpr_we", 32'(gpr_we), 32'(e.we));
        checkField(tag, "gpr_a3", 32'(gpr_a3), 32'(e.a3));
        checkField(tag, "gpr_wd", gpr_wd, e.wd);
        checkField(tag, "gpr_pc", gpr_pc, e.pc);
        checkField(tag, "pend_mask", pend_mask, e.pend);
        checkField(tag, "fifo_cnt", 32'(fifo_cnt), e.cnt);
        checkField(tag, "md_ready", 32'(md_ready), 32'(e.ready));
        checkField(tag, "waw_err", 32'(waw_err), 32'(e.waw));
    endtask

    // Drive at the falling edge, advance the model across the rising edge,
    // then compare at the next falling edge.
    task automatic applyStimulus(input stim_t s);
        bit   ready;
        ent_t e;
        reset = s.rst; pipe_we = s.pwe; pipe_a3 = s.pa3; pipe_wd = s.pwd; pipe_pc = s.ppc;
        md_valid = s.mv; md_a3 = s.ma3; md_wd = s.mwd; md_pc = s.mpc;
        @(posedge clk);
        if (s.rst) begin
            mq.delete();
            m_we = 0; m_a3 = '0; m_wd = '0; m_pc = '0; m_waw = 0;
        end else begin
            ready = (mq.size() != DEPTH);
            if (s.pwe && s.pa3 != 0) begin
                foreach (mq[i]) if (mq[i].a3 == s.pa3) m_waw = 1'b1;
                m_we = 1; m_a3 = s.pa3; m_wd = s.pwd; m_pc = s.ppc;
            end else if (mq.size() != 0) begin
                e = mq.pop_front();
                m_we = 1; m_a3 = e.a3; m_wd = e.wd; m_pc = e.pc;
            end else begin
                m_we = 0;
            end
            if (s.mv && ready && s.ma3 != 0) begin
                e.a3 = s.ma3; e.wd = s.mwd; e.pc = s.mpc;
                mq.push_back(e);
            end
        end
        @(negedge clk);
        if (gpr_we) obs.push_back(gpr_a3);
        checkOutput(model_exp(), "model");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t tbl[11];

    initial begin
        reset = 1; pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0;

        tbl[0]  = '{mk(1,0,0,0,0,0,0), mke(0,0,0,0,0,0,0,0)};
        tbl[1]  = '{mk(1,0,0,0,0,0,0), mke(0,0,0,0,0,0,0,0)};
        tbl[2]  = '{mk(0,0,0,0,1,5,32'h1234), mke(0,0,0,0,32'h20,1,1,0)};
        tbl[3]  = '{mk(0,0,0,0,0,0,0), mke(1,5,32'h1234,32'h3234,32'h20,0,1,0)};
        tbl[4]  = '{mk(0,0,0,0,0,0,0), mke(0,5,32'h1234,32'h3234,0,0,1,0)};
        tbl[5]  = '{mk(0,1,0,32'hBEEF,1,0,32'hDEAD), mke(0,5,32'h1234,32'h3234,0,0,1,0)};
        tbl[6]  = '{mk(0,0,0,0,0,0,0), mke(0,5,32'h1234,32'h3234,0,0,1,0)};
        tbl[7]  = '{mk(0,0,0,0,1,9,32'h99), mke(0,5,32'h1234,32'h3234,32'h200,1,1,0)};
        tbl[8]  = '{mk(0,1,9,32'h77,0,0,0), mke(1,9,32'h77,32'h1077,32'h200,1,1,1)};
        tbl[9]  = '{mk(0,0,0,0,0,0,0), mke(1,9,32'h99,32'h2099,32'h200,0,1,1)};
        tbl[10] = '{mk(0,0,0,0,0,0,0), mke(0,9,32'h99,32'h2099,0,0,1,1)};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].s);
            checkOutput(tbl[i].e, $sformatf("tbl%0d", i));
        end

        // Pipeline holds the port while the FIFO fills, then drains in order.
        obs.delete();
        applyStimulus(mk(0, 1, 3, 32'hAA, 1, 7, 32'h70));
        applyStimulus(mk(0, 1, 3, 32'hAA, 1, 8, 32'h80));
        applyStimulus(mk(0, 1, 3, 32'hAA, 0, 0, 0));
        applyStimulus(mk(0, 1, 3, 32'hAA, 0, 0, 0));
        vectors++;
        checkField("full", "fifo_cnt", 32'(fifo_cnt), 32'd2);
        checkField("full", "md_ready", 32'(md_ready), 32'd0);
        idle(3);
        vectors++;
        checkField("drain", "count", 32'(obs.size()), 32'd6);
        if (obs.size() == 6) begin
            checkField("drain", "w4", 32'(obs[4]), 32'd7);
            checkField("drain", "w5", 32'(obs[5]), 32'd8);
        end
        checkField("drain", "fifo_cnt", 32'(fifo_cnt), 32'd0);

        // Reset while full drops both entries without a write.
        applyStimulus(mk(0, 1, 3, 32'hAB, 1, 12, 32'hC0));
        applyStimulus(mk(0, 1, 3, 32'hAB, 1, 13, 32'hD0));
        obs.delete();
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
        checkOutput(mke(0, 0, 0, 0, 0, 0, 0, 0), "rstfull");
        idle(3);
        vectors++;
        checkField("rstfull", "writes", 32'(obs.size()), 32'd0);

        // Back-to-back transfers: one push and one pop per edge, pointers wrap.
        obs.delete();
        for (int i = 0; i < 10; i++) applyStimulus(mk(0, 0, 0, 0, 1, 5'(10 + i), 32'(i)));
        idle(2);
        vectors++;
        checkField("stream", "count", 32'(obs.size()), 32'd10);
        for (int i = 0; i < 10 && i < obs.size(); i++)
            checkField($sformatf("stream%0d", i), "gpr_a3", 32'(obs[i]), 32'(10 + i));

        // Random traffic against the model; small register range provokes WAW and $0.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(mk(($urandom_range(0, 49) == 0),
                             ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
                             ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
